// File: rtl/data_confreg_bridge_if.sv
// Word-wide SRAM-style request/response bus shared by the core port and the data RAM port.
interface data_confreg_bridge_if;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output en, output wen, output addr, output wdata, input  rdata);
   modport slave  (input  en, input  wen, input  addr, input  wdata, output rdata);
endinterface

// File: rtl/data_confreg_bridge.sv
// Routes core data-SRAM requests to the external data RAM or to a small configuration-register file,
// returning register reads with the same one-cycle latency as the RAM.
module data_confreg_bridge #(
   parameter logic [15:0] CONF_BASE = 16'hBFAF,
   parameter logic [31:0] SIMU_FLAG = 32'hFFFF_FFFF
) (
   input  logic                         clk,
   input  logic                         resetn,
   data_confreg_bridge_if.slave         cpu,
   data_confreg_bridge_if.master        ram,
   input  logic [7:0]                   switch,
   output logic [15:0]                  led,
   output logic [31:0]                  num_data
);
   localparam int unsigned DW = 32;
   localparam int unsigned LW = 16;
   localparam int unsigned SW = 8;

   localparam logic [15:0] OFF_TIMER  = 16'hE000;
   localparam logic [15:0] OFF_LED    = 16'hF000;
   localparam logic [15:0] OFF_SWITCH = 16'hF010;
   localparam logic [15:0] OFF_NUM    = 16'hF020;
   localparam logic [15:0] OFF_SIMU   = 16'hF030;

   logic          conf_hit_c;
   logic          conf_wr_c;
   logic [15:0]   offset_c;
   logic [DW-1:0] timer;
   logic [DW-1:0] timer_next_c;
   logic [LW-1:0] led_next_c;
   logic [DW-1:0] num_next_c;
   logic [SW-1:0] switch_meta;
   logic [SW-1:0] switch_sync;
   logic [DW-1:0] conf_rdata_c;
   logic          sel_conf_r;
   logic [DW-1:0] conf_rdata_r;

   // Replace the enabled bytes of old_v with those of new_v.
   function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [3:0]    be);
      logic [DW-1:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

   assign offset_c   = cpu.addr[15:0];
   assign conf_hit_c = cpu.en && (cpu.addr[31:16] == CONF_BASE);
   assign conf_wr_c  = conf_hit_c && (cpu.wen != 4'b0000);

   assign ram.en    = cpu.en && !conf_hit_c;
   assign ram.wen   = ram.en ? cpu.wen : 4'b0000;
   assign ram.addr  = cpu.addr;
   assign ram.wdata = cpu.wdata;

   // Next-state values of the writable registers; a timer write overrides the increment per byte.
   always_comb begin
      timer_next_c = timer + DW'(1);
      led_next_c   = led;
      num_next_c   = num_data;
      if (conf_wr_c) begin
         unique case (offset_c)
            OFF_TIMER: timer_next_c = byte_merge(timer + DW'(1), cpu.wdata, cpu.wen);
            OFF_LED:   led_next_c   = LW'(byte_merge(DW'(led), cpu.wdata, {2'b00, cpu.wen[1:0]}));
            OFF_NUM:   num_next_c   = byte_merge(num_data, cpu.wdata, cpu.wen);
            default:   ;
         endcase
      end
   end

   // Read mux over pre-edge register values.
   always_comb begin
      conf_rdata_c = '0;
      unique case (offset_c)
         OFF_TIMER:  conf_rdata_c = timer;
         OFF_LED:    conf_rdata_c = {16'h0000, led};
         OFF_SWITCH: conf_rdata_c = {24'h00_0000, switch_sync};
         OFF_NUM:    conf_rdata_c = num_data;
         OFF_SIMU:   conf_rdata_c = SIMU_FLAG;
         default:    conf_rdata_c = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timer        <= '0;
         led          <= 16'hFFFF;
         num_data     <= '0;
         switch_meta  <= '0;
         switch_sync  <= '0;
         sel_conf_r   <= 1'b0;
         conf_rdata_r <= '0;
      end else begin
         timer        <= timer_next_c;
         led          <= led_next_c;
         num_data     <= num_next_c;
         switch_meta  <= switch;
         switch_sync  <= switch_meta;
         sel_conf_r   <= conf_hit_c;
         if (conf_hit_c) conf_rdata_r <= conf_rdata_c;
      end
   end

   assign cpu.rdata = sel_conf_r ? conf_rdata_r : ram.rdata;
endmodule

// File: tb/tb_data_confreg_bridge.sv
// Directed bench for data_confreg_bridge: inputs change on the falling edge, outputs are checked there too.
module tb_data_confreg_bridge;
   logic        clk;
   logic        resetn;
   logic [7:0]  switch;
   logic [15:0] led;
   logic [31:0] num_data;
   int          total;
   int          passed;

   data_confreg_bridge_if cpu_bus ();
   data_confreg_bridge_if ram_bus ();

   data_confreg_bridge dut (
      .clk      (clk),
      .resetn   (resetn),
      .cpu      (cpu_bus),
      .ram      (ram_bus),
      .switch   (switch),
      .led      (led),
      .num_data (num_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic req(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata);
      cpu_bus.en    = en;
      cpu_bus.wen   = wen;
      cpu_bus.addr  = addr;
      cpu_bus.wdata = wdata;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      switch = 8'h00;
      ram_bus.rdata = 32'h1357_9BDF;
      req(1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk); @(negedge clk);
      total++; if (led !== 16'hFFFF) $display("FAIL reset_led: got %h want %h", led, 16'hFFFF); else passed++;
      total++; if (num_data !== 32'h0) $display("FAIL reset_num: got %h want %h", num_data, 32'h0); else passed++;
      total++; if (cpu_bus.rdata !== 32'h1357_9BDF) $display("FAIL reset_rdata: got %h want %h", cpu_bus.rdata, 32'h1357_9BDF); else passed++;
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_led_read();
      req(1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
      #1;
      total++; if (ram_bus.en !== 1'b0) $display("FAIL led_read_ram_en: got %b want 0", ram_bus.en); else passed++;
      @(negedge clk);
      req(1'b0, 4'h0, 32'h0, 32'h0);
      total++; if (cpu_bus.rdata !== 32'h0000_FFFF) $display("FAIL led_read: got %h want %h", cpu_bus.rdata, 32'h0000_FFFF); else passed++;
      total++; if (led !== 16'hFFFF) $display("FAIL led_value: got %h want %h", led, 16'hFFFF); else passed++;
   endtask

   task automatic test_num_write();
      req(1'b1, 4'hF, 32'hBFAF_F020, 32'hAAAA_AAAA);
      @(negedge clk);
      req(1'b1, 4'b0011, 32'hBFAF_F020, 32'h1234_5678);
      @(negedge clk);
      total++; if (num_data !== 32'hAAAA_5678) $display("FAIL num_partial: got %h want %h", num_data, 32'hAAAA_5678); else passed++;
      req(1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
      @(negedge clk);
      req(1'b0, 4'h0, 32'h0, 32'h0);
      total++; if (cpu_bus.rdata !== 32'hAAAA_5678) $display("FAIL num_readback: got %h want %h", cpu_bus.rdata, 32'hAAAA_5678); else passed++;
   endtask

   task automatic test_timer();
      req(1'b1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE);
      @(negedge clk);
      req(1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      req(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
      @(negedge clk);
      total++; if (cpu_bus.rdata !== 32'hFFFF_FFFF) $display("FAIL timer_pre_wrap: got %h want %h", cpu_bus.rdata, 32'hFFFF_FFFF); else passed++;
      @(negedge clk);
      total++; if (cpu_bus.rdata !== 32'h0000_0000) $display("FAIL timer_wrap: got %h want %h", cpu_bus.rdata, 32'h0); else passed++;
      // timer is 1 here; byte-1 write merges with the incremented value 2
      req(1'b1, 4'b0010, 32'hBFAF_E000, 32'h0000_AB00);
      @(negedge clk);
      req(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
      @(negedge clk);
      req(1'b0, 4'h0, 32'h0, 32'h0);
      total++; if (cpu_bus.rdata !== 32'h0000_AB02) $display("FAIL timer_byte_write: got %h want %h", cpu_bus.rdata, 32'h0000_AB02); else passed++;
   endtask

   task automatic test_back_to_back();
      logic prev_ram;
      prev_ram = 1'b0;
      ram_bus.rdata = 32'hDEAD_BEEF;
      for (int k = 0; k < 7; k++) begin
         if (k < 6) begin
            if (k % 2 == 0) req(1'b1, 4'h0, 32'h0000_0100, 32'h0);
            else            req(1'b1, 4'h0, 32'hBFAF_F030, 32'h0);
         end else begin
            req(1'b0, 4'h0, 32'h0, 32'h0);
         end
         #1;
         if (k < 6) begin
            total++;
            if (ram_bus.en !== (k % 2 == 0) || (k % 2 == 0 && ram_bus.addr !== 32'h0000_0100))
               $display("FAIL b2b_ram_req%0d: got en=%b addr=%h want en=%b", k, ram_bus.en, ram_bus.addr, (k % 2 == 0));
            else passed++;
         end
         if (k > 0) begin
            total++;
            if (cpu_bus.rdata !== (prev_ram ? 32'hDEAD_BEEF : 32'hFFFF_FFFF))
               $display("FAIL b2b_rdata%0d: got %h want %h", k - 1, cpu_bus.rdata,
                        prev_ram ? 32'hDEAD_BEEF : 32'hFFFF_FFFF);
            else passed++;
         end
         prev_ram = (k % 2 == 0);
         @(negedge clk);
      end
   endtask

   task automatic test_switch();
      switch = 8'h5A;
      @(negedge clk);
      req(1'b1, 4'h0, 32'hBFAF_F010, 32'h0);
      @(negedge clk);
      total++; if (cpu_bus.rdata !== 32'h0) $display("FAIL switch_early: got %h want %h", cpu_bus.rdata, 32'h0); else passed++;
      @(negedge clk);
      req(1'b0, 4'h0, 32'h0, 32'h0);
      total++; if (cpu_bus.rdata !== 32'h0000_005A) $display("FAIL switch_sync: got %h want %h", cpu_bus.rdata, 32'h5A); else passed++;
   endtask

   task automatic test_ro_unmapped();
      logic [31:0] addrs [6];
      logic [3:0]  wens  [6];
      logic [31:0] wdat  [6];
      logic [31:0] exp_r [6];
      logic        ram_wen_bad;
      addrs = '{32'hBFAF_F010, 32'hBFAF_F030, 32'hBFAF_F040, 32'hBFAF_F010, 32'hBFAF_F030, 32'hBFAF_F040};
      wens  = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
      wdat  = '{32'hFFFF_FFFF, 32'h0, 32'h1234_5678, 32'h0, 32'h0, 32'h0};
      exp_r = '{32'h0, 32'h0, 32'h0, 32'h0000_005A, 32'hFFFF_FFFF, 32'h0};
      ram_wen_bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         req(1'b1, wens[i], addrs[i], wdat[i]);
         #1;
         if (ram_bus.wen !== 4'h0) ram_wen_bad = 1'b1;
         @(negedge clk);
         if (i >= 3) begin
            total++;
            if (cpu_bus.rdata !== exp_r[i]) $display("FAIL ro_read%0d: got %h want %h", i, cpu_bus.rdata, exp_r[i]);
            else passed++;
         end
      end
      total++; if (ram_wen_bad !== 1'b0) $display("FAIL ro_ram_wen: got 1 want 0"); else passed++;
      // wen=0 on LED is a read and must not clear it
      req(1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
      @(negedge clk);
      req(1'b0, 4'h0, 32'h0, 32'h0);
      total++; if (led !== 16'hFFFF) $display("FAIL led_wen0: got %h want %h", led, 16'hFFFF); else passed++;
   endtask

   task automatic test_reset_mid();
      req(1'b1, 4'hF, 32'hBFAF_F000, 32'h9999_0000);
      @(negedge clk);
      total++; if (led !== 16'h0000) $display("FAIL led_write: got %h want %h", led, 16'h0); else passed++;
      ram_bus.rdata = 32'h2468_ACE0;
      req(1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
      @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      total++; if (cpu_bus.rdata !== 32'h2468_ACE0) $display("FAIL reset_mid_rdata: got %h want %h", cpu_bus.rdata, 32'h2468_ACE0); else passed++;
      total++; if (led !== 16'hFFFF || num_data !== 32'h0) $display("FAIL reset_mid_regs: got led=%h num=%h want FFFF/0", led, num_data); else passed++;
      req(1'b1, 4'h0, 32'h0000_0200, 32'h0);
      #1;
      total++; if (ram_bus.en !== 1'b1) $display("FAIL reset_mid_ram_en: got %b want 1", ram_bus.en); else passed++;
      @(negedge clk);
      req(1'b0, 4'h0, 32'h0, 32'h0);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      total  = 0;
      passed = 0;
      test_reset();
      test_led_read();
      test_num_write();
      test_timer();
      test_back_to_back();
      test_switch();
      test_ro_unmapped();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/data_confreg_bridge.md
# data_confreg_bridge

Address-decoding bridge between the core's data SRAM port and the SoC. Each request is routed either to the external data RAM or to a small configuration-register file. The register file holds LEDs, a seven-segment number, a 2-flop-synchronised switch input, a free-running timer and a simulation flag. Read data is returned with the same one-cycle latency as the synchronous data RAM, so the MEM stage sees a uniform interface.

## Interface
- CONF_BASE, 16'hBFAF: value of addr[31:16] that selects the register file.
- SIMU_FLAG, 32'hFFFF_FFFF: constant returned by the SIMU register.
- clk  in  1  clock; every register is updated on its rising edge.
- resetn  in  1  reset, asynchronous assert, active-low.
- data_sram_en  in  1  request valid this cycle, from the core.
- data_sram_wen  in  4  byte write enables; 0 means the request is a read.
- data_sram_addr  in  32  byte address, word-aligned.
- data_sram_wdata  in  32  write data.
- data_sram_rdata  out  32  read data, valid the cycle after the request.
- ram_en  out  1  request to the data RAM.
- ram_wen  out  4  byte write enables to the data RAM.
- ram_addr  out  32  address to the data RAM.
- ram_wdata  out  32  write data to the data RAM.
- ram_rdata  in  32  data RAM output, one cycle after ram_en.
- switch  in  8  asynchronous board switches.
- led  out  16  LED register, active-low.
- num_data  out  32  seven-segment display value.

## Operation
- Decode (combinational): conf_hit = data_sram_en && addr[31:16]==CONF_BASE.
- RAM routing:
  - ram_en = data_sram_en && !conf_hit.
  - ram_wen = data_sram_wen when ram_en is high, else 0.
  - ram_addr and ram_wdata pass through unchanged.
- Register map, selected by addr[15:0]:
  - 16'hE000 TIMER: RW, 32 bits.
  - 16'hF000 LED: RW; bits [15:0] are significant, reads return {16'h0, led}.
  - 16'hF010 SWITCH: RO; reads return {24'h0, switch_sync}.
  - 16'hF020 NUM: RW, 32 bits.
  - 16'hF030 SIMU: RO; reads return SIMU_FLAG.
  - Any other offset: reads return 0, writes are ignored.
- Writes: conf_hit with nonzero wen updates only the enabled bytes of RW registers. Writes to RO registers are ignored. For LED, wen[3:2] are ignored.
- Timer: increments by 1 every cycle and wraps 32'hFFFF_FFFF to 0.
  - A write in the same cycle overrides the increment for the enabled bytes.
  - Disabled bytes take the incremented value's bytes.
- Switch input: two-flop synchroniser; switch_sync is the second flop.
- Read return path, registered at the request edge:
  - sel_conf_r <= conf_hit.
  - conf_rdata_r <= the selected register's pre-edge value.
  - data_sram_rdata = sel_conf_r ? conf_rdata_r : ram_rdata.
- Reads through the register file have no side effects.
- Reset values:
  - led = 16'hFFFF.
  - num_data = 0, timer = 0, both synchroniser flops = 0.
  - sel_conf_r = 0, conf_rdata_r = 0, so data_sram_rdata follows ram_rdata.

## Timing
- Request in cycle N; data_sram_rdata is valid throughout cycle N+1 and is undefined afterwards unless another request is made.
- Register writes are visible on led and num_data from cycle N+1.
- A read issued in cycle N+1 returns the value written in cycle N.
- TIMER read in cycle N returns the timer value during cycle N, i.e. before that edge's increment.
- Back-to-back requests are accepted every cycle with no stall. A RAM read followed by a register read selects correctly per cycle via sel_conf_r.
- SWITCH read latency from a pin change is 2 cycles to switch_sync, plus 1 cycle return.
- Reset asserted mid-operation:
  - All state clears immediately (asynchronously).
  - A read pending across reset returns ram_rdata, not register data.
  - ram_en stays combinational from inputs.
- Write with wen=4'b0000 to a register address is a read; no register changes.

## Test plan
- Reset, then read 0xBFAF_F000 -> returns 32'h0000_FFFF next cycle; led = 16'hFFFF; ram_en stays 0 during the access.
- Write 0xBFAF_F020 with wen=4'b0011, wdata=32'h1234_5678 over num_data=32'hAAAA_AAAA -> num_data = 32'hAAAA_5678 next cycle; readback matches.
- Write TIMER 32'hFFFF_FFFE at cycle N; read TIMER at N+2 -> returns 32'hFFFF_FFFF, and the value is 32'h0000_0000 one cycle later (wrap).
- Alternate RAM read at 0x0000_0100 (ram_rdata=32'hDEAD_BEEF) with read of 0xBFAF_F030 every cycle -> rdata alternates 32'hDEAD_BEEF / 32'hFFFF_FFFF with 1-cycle latency and no stall.
- Set switch=8'h5A at cycle N; read SWITCH at N+1 -> 0; read at N+2 -> 32'h0000_005A.
- Write SWITCH and SIMU, and read unmapped offset 16'hF040 -> both RO registers unchanged; unmapped read returns 0; ram_wen stays 0 throughout.
